// File: rtl/mcu_decode_scheduler.sv
// Frame-level block/MCU sequencer for the JPEG decode pipeline.
// Gates entropy decode, tracks block/channel/MCU position and bounds MCUs in flight with credits.
//
// state | meaning
// IDLE  | waiting for an accepted frame start
// RUN   | entropy decoder enabled, blocks being counted
// STALL | credit limit reached, waiting for a downstream retire
// DRAIN | last MCU decoded, waiting for all MCUs to retire
// DONE  | one-cycle frame completion pulse
module mcu_decode_scheduler #(
    parameter int CREDITS = 2,
    parameter int DIM_W   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIM_W-1:0] mcu_w,
    input  logic [DIM_W-1:0] mcu_h,
    input  logic             sub_mode,
    input  logic             blk_done,
    input  logic             ret_mcu,
    output logic             decode_en,
    output logic [1:0]       ch_sel,
    output logic [2:0]       blk_idx,
    output logic [DIM_W-1:0] mcu_x,
    output logic [DIM_W-1:0] mcu_y,
    output logic             busy,
    output logic             frame_done,
    output logic             err
);

    localparam int OW = $clog2(CREDITS + 1);
    localparam logic [OW-1:0] CRED_MAX = OW'(CREDITS);

    typedef enum logic [2:0] {IDLE, RUN, STALL, DRAIN, DONE} state_t;

    state_t           state_q, state_d;
    logic [DIM_W-1:0] w_q, w_d, h_q, h_d, x_q, x_d, y_q, y_d;
    logic             sub_q, sub_d;
    logic [2:0]       blk_q, blk_d;
    logic [1:0]       ch_q, ch_d;
    logic [OW-1:0]    outst_q, outst_d;
    logic             err_q, err_d, en_q, en_d, busy_q, busy_d, fd_q, fd_d;
    logic [2:0]       last_idx;
    logic             mcu_done, last_mcu, ret_ok;

    always_comb begin
        state_d  = state_q;
        w_d      = w_q;
        h_d      = h_q;
        sub_d    = sub_q;
        x_d      = x_q;
        y_d      = y_q;
        blk_d    = blk_q;
        err_d    = err_q;
        last_idx = sub_q ? 3'd5 : 3'd2;
        mcu_done = (state_q == RUN) && blk_done && (blk_q == last_idx);
        last_mcu = (x_q == w_q - DIM_W'(1)) && (y_q == h_q - DIM_W'(1));
        ret_ok   = ret_mcu && (outst_q != '0);
        outst_d  = outst_q + OW'(mcu_done) - OW'(ret_ok);

        if (blk_done && state_q != RUN) err_d = 1'b1;
        if (ret_mcu && outst_q == '0)   err_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (mcu_w != '0 && mcu_h != '0) begin
                        state_d = RUN;
                        w_d     = mcu_w;
                        h_d     = mcu_h;
                        sub_d   = sub_mode;
                        x_d     = '0;
                        y_d     = '0;
                        blk_d   = '0;
                        outst_d = '0;
                        err_d   = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (blk_done) blk_d = (blk_q == last_idx) ? 3'd0 : blk_q + 3'd1;
                if (mcu_done) begin
                    // Final position is held so it stays observable through DRAIN.
                    if (last_mcu) begin
                        state_d = DRAIN;
                    end else begin
                        if (x_q == w_q - DIM_W'(1)) begin
                            x_d = '0;
                            y_d = y_q + DIM_W'(1);
                        end else begin
                            x_d = x_q + DIM_W'(1);
                        end
                        if (outst_d == CRED_MAX) state_d = STALL;
                    end
                end
            end
            STALL: if (ret_mcu) state_d = RUN;
            DRAIN: if (outst_d == '0) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (sub_d) ch_d = (blk_d < 3'd4) ? 2'd0 : ((blk_d == 3'd4) ? 2'd1 : 2'd2);
        else       ch_d = blk_d[1:0];
        en_d   = (state_d == RUN);
        busy_d = (state_d != IDLE);
        fd_d   = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            w_q     <= '0;
            h_q     <= '0;
            sub_q   <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            blk_q   <= '0;
            ch_q    <= '0;
            outst_q <= '0;
            err_q   <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            h_q     <= h_d;
            sub_q   <= sub_d;
            x_q     <= x_d;
            y_q     <= y_d;
            blk_q   <= blk_d;
            ch_q    <= ch_d;
            outst_q <= outst_d;
            err_q   <= err_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            fd_q    <= fd_d;
        end
    end

    assign decode_en  = en_q;
    assign ch_sel     = ch_q;
    assign blk_idx    = blk_q;
    assign mcu_x      = x_q;
    assign mcu_y      = y_q;
    assign busy       = busy_q;
    assign frame_done = fd_q;
    assign err        = err_q;

endmodule
